// File: rtl/hyp_range_reduce.sv
// Range reduction z = q*ln2 + r ahead of the hyperbolic CORDIC.
// Shift-add multipliers, one operation in flight, valid/ready on both sides.
module hyp_range_reduce #(
  parameter int FRAC_BITS = 32,
  parameter int QW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   zin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   r_out,
  output logic [QW-1:0] q_out,
  output logic          ovf,
  output logic          nan
);

  localparam int F   = FRAC_BITS;
  localparam int AW  = F + 7;
  localparam int MW  = F + 1;
  localparam int PW  = AW + F + 1;
  localparam int RW  = F + 9;
  localparam int CW  = $clog2(F + 2);
  localparam int PSW = $clog2(RW);

  localparam logic [64:0] INV_LN2_64 = 65'h1_7154_7652_B82F_E177;
  localparam logic [63:0] LN2_64     = 64'hB172_17F7_D1CF_79AB;
  localparam logic [MW-1:0] INV_LN2  = MW'(INV_LN2_64 >> (64 - F));
  localparam logic [F-1:0]  LN2      = F'(LN2_64 >> (64 - F));
  localparam logic [PW-1:0] HALF     = PW'(1) << (2 * F - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, MUL1, RND, MUL2, SUB, NORM, DONE
  } state_t;

  state_t state, state_n;

  logic [31:0]    zr;
  logic [AW-1:0]  az;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  mcand;
  logic [MW-1:0]  mplier;
  logic [CW-1:0]  cnt;
  logic [7:0]     qm;
  logic [RW-1:0]  rf;
  logic           pass;

  logic           s;
  logic [7:0]     e;
  logic [23:0]    man;
  logic [7:0]     sh;
  logic [AW-1:0]  az_n;
  logic           cls_nan;
  logic           cls_ovf;
  logic           cls_exc;
  logic [7:0]     qm_n;

  assign s       = zr[31];
  assign e       = zr[30:23];
  assign man     = {1'b1, zr[22:0]};
  assign sh      = e - 8'(150 - F);
  assign az_n    = AW'(man) << sh;
  assign cls_nan = (e == 8'd255);
  assign cls_ovf = !cls_nan && (e >= 8'd134);
  assign cls_exc = cls_nan || cls_ovf || (e <= 8'd125);
  assign qm_n    = 8'((acc + HALF) >> (2 * F));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = LOAD;
      LOAD: state_n = cls_exc ? NORM : MUL1;
      MUL1: if (cnt == CW'(F)) state_n = RND;
      RND:  state_n = MUL2;
      MUL2: if (cnt == CW'(7)) state_n = SUB;
      SUB:  state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [RW-1:0]  mag;
  logic [PSW-1:0] pos;
  logic [7:0]     r_exp;
  logic [22:0]    r_man;
  logic [31:0]    r_norm;
  logic [QW-1:0]  qmag;
  logic [QW-1:0]  q_norm;

  always_comb begin
    mag = rf[RW-1] ? (~rf + 1'b1) : rf;
    pos = '0;
    for (int i = 0; i < RW; i++) begin
      if (mag[i]) pos = PSW'(i);
    end
    r_exp = 8'(127 - F + int'(pos));
    r_man = 23'((pos >= PSW'(23)) ? (mag >> (pos - PSW'(23)))
                                  : (mag << (PSW'(23) - pos)));
    r_norm = (mag == '0) ? 32'h0 : {s ^ rf[RW-1], r_exp, r_man};
    qmag   = QW'(qm);
    q_norm = s ? (~qmag + 1'b1) : qmag;
  end

  // Exceptions detour through NORM so every LOAD-classified path takes 2 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      zr     <= '0;
      az     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      qm     <= '0;
      rf     <= '0;
      pass   <= 1'b0;
      r_out  <= '0;
      q_out  <= '0;
      ovf    <= 1'b0;
      nan    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            zr   <= zin;
            ovf  <= 1'b0;
            nan  <= 1'b0;
            pass <= 1'b0;
          end
        end
        LOAD: begin
          az     <= az_n;
          acc    <= '0;
          cnt    <= '0;
          mcand  <= PW'(az_n);
          mplier <= INV_LN2;
          if (cls_exc) begin
            pass  <= 1'b1;
            nan   <= cls_nan;
            ovf   <= cls_ovf;
            r_out <= zr;
            q_out <= '0;
          end
        end
        MUL1, MUL2: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        RND: begin
          qm     <= qm_n;
          acc    <= '0;
          cnt    <= '0;
          mcand  <= PW'(LN2);
          mplier <= MW'(qm_n);
        end
        SUB: begin
          rf <= RW'({2'b00, az}) - RW'({1'b0, acc[F+7:0]});
        end
        NORM: begin
          if (!pass) begin
            r_out <= r_norm;
            q_out <= q_norm;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyp_range_reduce.sv
// Scoreboard bench for hyp_range_reduce against a real-valued reference.
// Expectations are queued at each accept and popped when out_valid rises.
module tb_hyp_range_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] zin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r_out;
  logic [8:0]  q_out;
  logic        ovf;
  logic        nan;

  hyp_range_reduce #(.FRAC_BITS(32), .QW(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .zin(zin),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_out(r_out), .q_out(q_out), .ovf(ovf), .nan(nan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int hs_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) hs_cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] z;
    longint      q;
    longint      r;
    longint      tol;
    bit          exact;
    bit          ovf;
    bit          nan;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  real LN2;

  task automatic check(input string tag, input longint obs,
                       input longint exp, input longint tol);
    checks++;
    if (obs - exp > tol || exp - obs > tol) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint ord(input logic [31:0] b);
    longint m;
    m = longint'(b[30:0]);
    return b[31] ? -m : m;
  endfunction

  function automatic real bits2real(input logic [31:0] b);
    real v;
    v = (1.0 + real'(b[22:0]) / 8388608.0)
        * (2.0 ** real'(int'(b[30:23]) - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] real2bits(input real x);
    real a;
    int  ex;
    int  m;
    if (x == 0.0) return 32'h0;
    a  = (x < 0.0) ? -x : x;
    ex = 0;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0)  begin a = a * 2.0; ex--; end
    m = $rtoi((a - 1.0) * 8388608.0);
    return {(x < 0.0) ? 1'b1 : 1'b0, 8'(ex + 127), 23'(m)};
  endfunction

  function automatic exp_t model(input logic [31:0] z);
    exp_t x;
    real  a, qq, r;
    int   ex;
    ex = int'(z[30:23]);
    x.z = z; x.q = 0; x.r = 0; x.tol = 0;
    x.exact = 1'b1; x.ovf = 1'b0; x.nan = 1'b0;
    x.lat = 2; x.acc = 0;
    if (ex == 255) x.nan = 1'b1;
    else if (ex >= 134) x.ovf = 1'b1;
    else if (ex >= 126) begin
      a  = bits2real(z);
      a  = (a < 0.0) ? -a : a;
      qq = $floor(a / LN2 + 0.5);
      r  = a - qq * LN2;
      if (z[31]) r = -r;
      x.q     = z[31] ? -longint'($rtoi(qq)) : longint'($rtoi(qq));
      x.r     = ord(real2bits(r));
      x.tol   = 2;
      x.exact = 1'b0;
      x.lat   = 45;
    end
    return x;
  endfunction

  bit   seen = 1'b0;
  exp_t em;
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) check("spurious_out", 1, 0, 0);
      else begin
        em = sb.pop_front();
        check($sformatf("lat[%h]", em.z), cyc - em.acc, em.lat, 0);
        check($sformatf("q[%h]", em.z), longint'($signed(q_out)), em.q, 0);
        if (em.exact)
          check($sformatf("r_exact[%h]", em.z), longint'(r_out),
                longint'(em.z), 0);
        else
          check($sformatf("r_ulp[%h]", em.z), ord(r_out), em.r, em.tol);
        check($sformatf("ovf[%h]", em.z), longint'(ovf), longint'(em.ovf), 0);
        check($sformatf("nan[%h]", em.z), longint'(nan), longint'(em.nan), 0);
      end
    end else if (!out_valid) seen = 1'b0;
  end

  task automatic send(input logic [31:0] z);
    int   n;
    bit   rdy;
    exp_t x;
    n = 0;
    zin = z;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("accept_timeout", 0, 1, 0);
    else begin
      x = model(z);
      x.acc = cyc;
      sb.push_back(x);
    end
    in_valid = 1'b0;
    zin = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1, 0);
    check({tag, "_out_valid"}, longint'(out_valid), 0, 0);
    check({tag, "_r_out"}, longint'(r_out), 0, 0);
    check({tag, "_q_out"}, longint'(q_out), 0, 0);
    check({tag, "_ovf"}, longint'(ovf), 0, 0);
    check({tag, "_nan"}, longint'(nan), 0, 0);
  endtask

  logic [31:0] vec [12] = '{
    32'h3F800000, 32'h41200000, 32'hC0400000, 32'h3F000000,
    32'h3E800000, 32'h80000000, 32'h00000001, 32'h3EFFFFFF,
    32'h43480000, 32'h43000000, 32'h7FC00000, 32'hFF800000
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] z, r_cap;
    logic [8:0]  q_cap;
    real         a, t, fr, rr;
    int          n, tries;
    LN2 = $ln(2.0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; zin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    foreach (vec[i]) begin
      send(vec[i]);
      wait_idle();
    end

    for (int k = 0; k < 6; k++) begin
      tries = 0;
      do begin
        z = {1'($urandom), 8'(126 + $urandom_range(0, 4)), 23'($urandom)};
        a = bits2real(z);
        a = (a < 0.0) ? -a : a;
        t = a / LN2;
        fr = t - $floor(t);
        rr = a - $floor(t + 0.5) * LN2;
        rr = (rr < 0.0) ? -rr : rr;
        tries++;
      end while ((rr < 0.125 || (fr > 0.499 && fr < 0.501)) && tries < 1000);
      send(z);
      wait_idle();
    end

    out_ready = 1'b0;
    send(32'h3F800000);
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b1; zin = 32'h41200000;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) check("hold_timeout", 0, 1, 0);
    r_cap = r_out; q_cap = q_out;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold_valid%0d", c), longint'(out_valid), 1, 0);
      check($sformatf("hold_ready%0d", c), longint'(in_ready), 0, 0);
      check($sformatf("hold_r%0d", c), longint'(r_out), longint'(r_cap), 0);
      check($sformatf("hold_q%0d", c), longint'(q_out), longint'(q_cap), 0);
    end
    out_ready = 1'b1;
    wait_idle();

    send(32'h3F800000);
    send(32'hC0400000);
    check("b2b_gap", longint'(sb[$].acc - hs_cyc), 1, 0);
    wait_idle();

    send(32'h41200000);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_reset_state("abort");
    send(32'h3F800000);
    wait_idle();

    check("sb_empty", longint'(sb.size()), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyp_range_reduce.md
Name: hyp_range_reduce

Overview:
- Sequential argument range-reduction stage that sits directly upstream of the combinational hyperbolic CORDIC (sinh/cosh/tanh). That CORDIC converges only for |z| up to about 1.1.
- Takes an IEEE-754 single-precision z and splits it as z = q*ln2 + r, with |r| <= ln2/2.
- Emits r as float32 and q as a signed integer, so a downstream reconstruct stage can scale by 2^q.
- Uses a valid/ready handshake on both sides and shift-add multipliers that iterate over multiple cycles.

Parameters:
- FRAC_BITS, 32: fraction bits of the internal fixed-point magnitude. INV_LN2 and LN2 are held at 64 fractional bits and truncated to FRAC_BITS. Normal-path latency is FRAC_BITS+13.
- QW, 9: width of the signed q_out. Must cover ±185.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  zin is valid.
- in_ready  out  1  block can accept; high only in IDLE.
- zin  in  32  float32 argument.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- r_out  out  32  float32 reduced argument.
- q_out  out  QW  signed multiple of ln2.
- ovf  out  1  |z| >= 128.
- nan  out  1  zin exponent field is 255 (NaN or Inf).

Behaviour:
- Reset state: state=IDLE, in_ready=1, out_valid=0, r_out=0, q_out=0, ovf=0, nan=0. All internal accumulators and counters are cleared. Reset in any state aborts the operation in progress; no output is produced for it.
- States and transitions:
  - IDLE -> LOAD on in_valid&in_ready. zin is captured at that edge.
  - LOAD: unpack sign s, exponent e, mantissa {1,m}, then classify:
    - e==255: nan=1, q=0, r_out=zin -> DONE.
    - e>=134 (|z|>=128): ovf=1, q=0, r_out=zin -> DONE.
    - e<=125 (|z|<0.5, including zero and denormals): bypass, q=0, r_out=zin bit-exact -> DONE.
    - Otherwise: build |z| as unsigned Q7.FRAC_BITS -> MUL1.
  - MUL1: shift-add |z| x INV_LN2 (Q1.FRAC_BITS), one multiplier bit per cycle, FRAC_BITS+1 cycles -> RND.
  - RND: qm = integer part of (product + 0.5 LSB of the integer part), i.e. round half up. qm is at most 185 -> MUL2.
  - MUL2: shift-add qm x LN2, one bit per cycle, 8 cycles -> SUB.
  - SUB: rf = |z| - qm*LN2, signed, FRAC_BITS fraction -> NORM.
  - NORM: one cycle.
    - Leading-one detect on |rf|; mantissa truncated (no rounding), exponent = 127 + position - FRAC_BITS.
    - r sign = s XOR (rf<0).
    - rf==0 gives r_out=0x00000000.
    - q_out = s ? -qm : qm -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE, and out_valid drops the next cycle.
- Latency, accept edge to out_valid: normal path exactly FRAC_BITS+13 = 45 cycles; all LOAD-classified paths exactly 2 cycles.
- Throughput: one operation in flight. in_ready=0 in every state except IDLE, so there is no same-cycle accept on the DONE->IDLE edge.
- r_out, q_out, ovf and nan are stable from out_valid rise until the handshake completes. Flags are cleared on the next accept.
- in_valid without in_ready is ignored; zin is sampled only at the accept edge.
- Accuracy on the normal path: |r_out - (z - q*ln2)| <= 2 ulp of r_out, or <= 2^-30 absolute, whichever is larger.

Test Plan:
- Normal path, z=1.0 (0x3F800000) -> q_out=1, r_out≈0.3068528 (exponent field 125), sign positive, out_valid exactly 45 cycles after accept.
- Normal path, large positive, z=10.0 (0x41200000) -> q_out=14, r_out≈0.2959340. Negative input, z=-3.0 (0xC0400000) -> q_out=-4, r_out≈-0.2274113.
- Bypass, z=0.25 (0x3E800000), z=-0.0 and denormal 0x00000001 -> q_out=0, r_out equals zin bit-exact, latency 2, ovf=nan=0.
- Exceptions, z=200.0 (0x43480000) -> ovf=1, q_out=0. z=0x7FC00000 -> nan=1. z=0xFF800000 -> nan=1, latency 2.
- Handshake: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; in_valid pulses during busy are ignored. Back-to-back operations with out_ready=1 -> next accept one cycle after the DONE->IDLE transition.
- Reset: assert rst during MUL1 of z=10.0 -> next cycle in_ready=1, out_valid=0, all outputs 0. A following z=1.0 completes correctly in 45 cycles.
